// File: rtl/connect4_pkg.sv
// Shared definitions for the drop controller: board defaults, index widths,
// FSM state and player encodings.
package connect4_pkg;

    localparam int unsigned DEF_NUM_COLS = 7;
    localparam int unsigned DEF_NUM_ROWS = 6;
    localparam int unsigned COL_W        = 3;
    localparam int unsigned ROW_W        = 3;
    localparam int unsigned HEIGHT_W     = 4;
    localparam int unsigned COUNT_W      = 7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StFull = 2'd2
    } state_e;

    typedef enum logic {
        Player0 = 1'b0,
        Player1 = 1'b1
    } player_e;

endpackage

// File: rtl/rise_edge.sv
// Converts a synchronous enable level into a one-cycle event on its 0->1 transition.
module rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_event
);

    logic r_hist;

    // History resets high so a level already asserted at reset release is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= i_level;
        end
    end

    assign o_event = i_level & ~r_hist;

endmodule

// File: rtl/drop_controller.sv
// Connect-four cursor/drop controller with a valid/ready drop request towards the board writer.
// Define DROP_CURSOR_WRAP_EN to make the cursor wrap at the edges instead of saturating.
module drop_controller
    import connect4_pkg::*;
#(
    parameter int unsigned NUM_COLS = DEF_NUM_COLS,
    parameter int unsigned NUM_ROWS = DEF_NUM_ROWS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             left_en,
    input  logic             right_en,
    input  logic             drop_en,
    input  logic             new_game,
    input  logic             drop_ready,
    output logic [COL_W-1:0] cursor_col,
    output logic             drop_valid,
    output logic [COL_W-1:0] drop_col,
    output logic [ROW_W-1:0] drop_row,
    output logic             drop_player,
    output logic             cur_player,
    output logic             col_full,
    output logic             board_full
);

    localparam logic [COL_W-1:0]    LAST_COL = COL_W'(NUM_COLS - 1);
    localparam logic [COL_W-1:0]    HOME_COL = COL_W'(NUM_COLS / 2);
    localparam logic [HEIGHT_W-1:0] ROWS_H   = HEIGHT_W'(NUM_ROWS);
    localparam logic [COUNT_W-1:0]  TOTAL    = COUNT_W'(NUM_COLS * NUM_ROWS);

    logic w_left_ev, w_right_ev, w_drop_ev;

    rise_edge u_left_edge  (.clk(clk), .rst_n(rst_n), .i_level(left_en),  .o_event(w_left_ev));
    rise_edge u_right_edge (.clk(clk), .rst_n(rst_n), .i_level(right_en), .o_event(w_right_ev));
    rise_edge u_drop_edge  (.clk(clk), .rst_n(rst_n), .i_level(drop_en),  .o_event(w_drop_ev));

    state_e                r_state, w_state_nxt;
    logic [COL_W-1:0]      r_cursor, w_cursor_nxt;
    logic [HEIGHT_W-1:0]   r_height [NUM_COLS];
    logic [HEIGHT_W-1:0]   w_height_nxt [NUM_COLS];
    logic [COUNT_W-1:0]    r_count, w_count_nxt, w_count_inc;
    player_e               r_cur_player, w_cur_player_nxt;
    logic                  r_drop_valid, w_drop_valid_nxt;
    logic [COL_W-1:0]      r_drop_col, w_drop_col_nxt;
    logic [ROW_W-1:0]      r_drop_row, w_drop_row_nxt;
    player_e               r_drop_player, w_drop_player_nxt;
    logic                  w_col_full;

    assign w_col_full  = (r_height[r_cursor] >= ROWS_H);
    assign w_count_inc = r_count + COUNT_W'(1);

    always_comb begin
        w_state_nxt       = r_state;
        w_cursor_nxt      = r_cursor;
        w_height_nxt      = r_height;
        w_count_nxt       = r_count;
        w_cur_player_nxt  = r_cur_player;
        w_drop_valid_nxt  = r_drop_valid;
        w_drop_col_nxt    = r_drop_col;
        w_drop_row_nxt    = r_drop_row;
        w_drop_player_nxt = r_drop_player;

        if (new_game) begin
            w_state_nxt       = StIdle;
            w_cursor_nxt      = HOME_COL;
            for (int i = 0; i < NUM_COLS; i++) w_height_nxt[i] = '0;
            w_count_nxt       = '0;
            w_cur_player_nxt  = Player0;
            w_drop_valid_nxt  = 1'b0;
            w_drop_col_nxt    = '0;
            w_drop_row_nxt    = '0;
            w_drop_player_nxt = Player0;
        end else begin
            case (r_state)
                StIdle: begin
                    // A drop event swallows any same-cycle move, even when the column is full.
                    if (w_drop_ev) begin
                        if (!w_col_full) begin
                            w_state_nxt       = StReq;
                            w_drop_valid_nxt  = 1'b1;
                            w_drop_col_nxt    = r_cursor;
                            w_drop_row_nxt    = ROW_W'(r_height[r_cursor]);
                            w_drop_player_nxt = r_cur_player;
                        end
                    end else if (w_left_ev && !w_right_ev) begin
`ifdef DROP_CURSOR_WRAP_EN
                        w_cursor_nxt = (r_cursor == '0) ? LAST_COL : r_cursor - COL_W'(1);
`else
                        if (r_cursor != '0) w_cursor_nxt = r_cursor - COL_W'(1);
`endif
                    end else if (w_right_ev && !w_left_ev) begin
`ifdef DROP_CURSOR_WRAP_EN
                        w_cursor_nxt = (r_cursor == LAST_COL) ? '0 : r_cursor + COL_W'(1);
`else
                        if (r_cursor != LAST_COL) w_cursor_nxt = r_cursor + COL_W'(1);
`endif
                    end
                end
                StReq: begin
                    if (r_drop_valid && drop_ready) begin
                        if (r_height[r_drop_col] < ROWS_H) begin
                            w_height_nxt[r_drop_col] = r_height[r_drop_col] + HEIGHT_W'(1);
                        end
                        w_cur_player_nxt = player_e'(~r_cur_player);
                        w_count_nxt      = w_count_inc;
                        w_drop_valid_nxt = 1'b0;
                        w_state_nxt      = (w_count_inc >= TOTAL) ? StFull : StIdle;
                    end
                end
                StFull: begin
                    w_drop_valid_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt      = StIdle;
                    w_drop_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_cursor      <= HOME_COL;
            for (int i = 0; i < NUM_COLS; i++) r_height[i] <= '0;
            r_count       <= '0;
            r_cur_player  <= Player0;
            r_drop_valid  <= 1'b0;
            r_drop_col    <= '0;
            r_drop_row    <= '0;
            r_drop_player <= Player0;
        end else begin
            r_state       <= w_state_nxt;
            r_cursor      <= w_cursor_nxt;
            r_height      <= w_height_nxt;
            r_count       <= w_count_nxt;
            r_cur_player  <= w_cur_player_nxt;
            r_drop_valid  <= w_drop_valid_nxt;
            r_drop_col    <= w_drop_col_nxt;
            r_drop_row    <= w_drop_row_nxt;
            r_drop_player <= w_drop_player_nxt;
        end
    end

    assign cursor_col  = r_cursor;
    assign drop_valid  = r_drop_valid;
    assign drop_col    = r_drop_col;
    assign drop_row    = r_drop_row;
    assign drop_player = r_drop_player;
    assign cur_player  = r_cur_player;
    assign col_full    = w_col_full;
    assign board_full  = (r_state == StFull);

endmodule

// File: tb/tb_drop_controller.sv
// Directed bench for drop_controller; expectations follow DROP_CURSOR_WRAP_EN when defined.
module tb_drop_controller;

`ifdef DROP_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       left_en = 1'b0, right_en = 1'b0, drop_en = 1'b0;
    logic       new_game = 1'b0, drop_ready = 1'b1;
    logic [2:0] cursor_col, drop_col, drop_row;
    logic       drop_valid, drop_player, cur_player, col_full, board_full;

    int vectors = 0;
    int miscompares = 0;

    // Bench-side model of the board.
    int exp_cur = 3;
    int exp_player = 0;
    int exp_h [7];

    drop_controller dut (
        .clk(clk), .rst_n(rst_n), .left_en(left_en), .right_en(right_en), .drop_en(drop_en),
        .new_game(new_game), .drop_ready(drop_ready), .cursor_col(cursor_col),
        .drop_valid(drop_valid), .drop_col(drop_col), .drop_row(drop_row),
        .drop_player(drop_player), .cur_player(cur_player), .col_full(col_full),
        .board_full(board_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_cur = 3;
        exp_player = 0;
        for (int i = 0; i < 7; i++) exp_h[i] = 0;
    endtask

    task automatic pulse(input logic l, input logic r, input logic d);
        left_en = l; right_en = r; drop_en = d;
        tick();
        left_en = 1'b0; right_en = 1'b0; drop_en = 1'b0;
        tick();
    endtask

    task automatic goto_col(input int col);
        while (exp_cur != col) begin
            if (exp_cur > col) begin
                pulse(1'b1, 1'b0, 1'b0);
                exp_cur--;
            end else begin
                pulse(1'b0, 1'b1, 1'b0);
                exp_cur++;
            end
        end
        check("cursor_goto", cursor_col, col);
    endtask

    // Accepted drop at the model cursor with drop_ready high.
    task automatic do_drop();
        drop_en = 1'b1;
        tick();
        check("drop_valid_set", drop_valid, 1);
        check("drop_col", drop_col, exp_cur);
        check("drop_row", drop_row, exp_h[exp_cur]);
        check("drop_player", drop_player, exp_player);
        drop_en = 1'b0;
        tick();
        check("drop_valid_clr", drop_valid, 0);
        exp_h[exp_cur]++;
        exp_player ^= 1;
        check("cur_player", cur_player, exp_player);
    endtask

    initial begin
        model_clear();
        tick();
        tick();
        check("rst_cursor", cursor_col, 3);
        check("rst_valid", drop_valid, 0);
        check("rst_player", cur_player, 0);
        check("rst_dcol", drop_col, 0);
        check("rst_drow", drop_row, 0);
        check("rst_dplayer", drop_player, 0);
        check("rst_col_full", col_full, 0);
        check("rst_board_full", board_full, 0);
        rst_n = 1'b1;
        tick();

        // First drop and filling column 3
        do_drop();
        check("player_after_first", cur_player, 1);
        for (int i = 1; i < 6; i++) do_drop();
        check("col3_full", col_full, 1);
        drop_en = 1'b1;
        tick();
        check("full_col_no_valid", drop_valid, 0);
        drop_en = 1'b0;
        tick();
        check("full_col_player", cur_player, exp_player);

        // Cursor edges and simultaneous moves
        goto_col(0);
        pulse(1'b1, 1'b0, 1'b0);
        exp_cur = WRAP ? 6 : 0;
        check("left_at_0", cursor_col, exp_cur);
        pulse(1'b1, 1'b1, 1'b0);
        check("left_right_same", cursor_col, exp_cur);
        goto_col(6);
        pulse(1'b0, 1'b1, 1'b0);
        exp_cur = WRAP ? 0 : 6;
        check("right_at_6", cursor_col, exp_cur);

        // Drop beats a same-cycle left move
        goto_col(2);
        left_en = 1'b1; drop_en = 1'b1;
        tick();
        check("drop_beats_left_valid", drop_valid, 1);
        check("drop_beats_left_col", drop_col, 2);
        left_en = 1'b0; drop_en = 1'b0;
        tick();
        exp_h[2]++;
        exp_player ^= 1;
        check("drop_beats_left_cursor", cursor_col, 2);

        // Backpressure: events during a stalled request are discarded
        goto_col(0);
        drop_ready = 1'b0;
        drop_en = 1'b1;
        tick();
        drop_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            right_en = (i % 2 == 0);
            drop_en  = (i % 2 == 1);
            tick();
            check("stall_valid", drop_valid, 1);
            check("stall_col", drop_col, 0);
            check("stall_row", drop_row, 0);
            check("stall_player", drop_player, exp_player);
            check("stall_cursor", cursor_col, 0);
        end
        right_en = 1'b0; drop_en = 1'b0; drop_ready = 1'b1;
        tick();
        check("stall_release_valid", drop_valid, 0);
        tick();
        exp_h[0]++;
        exp_player ^= 1;
        check("stall_one_toggle", cur_player, exp_player);
        check("stall_cursor_after", cursor_col, 0);
        do_drop();
        check("stall_one_handshake_row", exp_h[0], 2);

        // Fill the whole board after a new game
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
        check("ng_cursor", cursor_col, 3);
        check("ng_player", cur_player, 0);
        check("ng_col_full", col_full, 0);
        for (int c = 0; c < 7; c++) begin
            goto_col(c);
            for (int r = 0; r < 6; r++) do_drop();
            if (c < 6) check("not_full_yet", board_full, 0);
        end
        check("board_full", board_full, 1);
        left_en = 1'b1; drop_en = 1'b1;
        tick();
        check("full_no_valid", drop_valid, 0);
        left_en = 1'b0; drop_en = 1'b0;
        tick();
        check("full_cursor_frozen", cursor_col, 6);
        check("full_still", board_full, 1);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
        check("ng2_cursor", cursor_col, 3);
        check("ng2_board_full", board_full, 0);
        check("ng2_player", cur_player, 0);
        check("ng2_col_full", col_full, 0);
        do_drop();

        // new_game abandons a pending request
        drop_ready = 1'b0;
        drop_en = 1'b1;
        tick();
        check("pend_valid", drop_valid, 1);
        check("pend_row", drop_row, 1);
        drop_en = 1'b0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        model_clear();
        check("ng_abandon_valid", drop_valid, 0);
        check("ng_abandon_player", cur_player, 0);

        // Async reset during a request, with drop held across release
        tick();
        drop_en = 1'b1;
        tick();
        check("pre_rst_valid", drop_valid, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", drop_valid, 0);
        tick();
        rst_n = 1'b1;
        drop_ready = 1'b1;
        tick();
        tick();
        check("held_no_event", drop_valid, 0);
        drop_en = 1'b0;
        tick();
        model_clear();
        do_drop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
